// File: rtl/gaussian_pkg.sv
// ---------------------------------------------------------------------------
// gaussian_pkg
// Shared definitions for the Gaussian window path: window geometry, the
// window-builder FSM state type and a tap-position helper.
// ---------------------------------------------------------------------------
package gaussian_pkg;

    localparam int WIN_SIZE   = 5;
    localparam int WIN_TAPS   = 25;
    localparam int CENTER_TAP = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Flat tap number of (row, column) inside the window vector.
    function automatic int tap_index(input int r, input int c);
        return r * WIN_SIZE + c;
    endfunction

endpackage

// File: rtl/win_col_shift.sv
// ---------------------------------------------------------------------------
// win_col_shift
// Five-deep column shift register for one window row. On each shift the
// newest pixel enters column 4 and column 0 (leftmost) drops out.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   shift_en    advance the register by one column
//   din         newest pixel of this row
//   taps        column c at bits [c*DATA_WIDTH +: DATA_WIDTH], c=0 oldest
// ---------------------------------------------------------------------------
module win_col_shift
    import gaussian_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           shift_en,
    input  logic [DATA_WIDTH-1:0]          din,
    output logic [WIN_SIZE*DATA_WIDTH-1:0] taps
);

    logic [DATA_WIDTH-1:0] col_r [WIN_SIZE];

    // Column storage: shift left by one position on every enabled sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < WIN_SIZE; c++) begin
                col_r[c] <= '0;
            end
        end else if (shift_en) begin
            for (int c = 0; c < WIN_SIZE - 1; c++) begin
                col_r[c] <= col_r[c+1];
            end
            col_r[WIN_SIZE-1] <= din;
        end else begin
            for (int c = 0; c < WIN_SIZE; c++) begin
                col_r[c] <= col_r[c];
            end
        end
    end

    // Flatten the columns into the tap vector.
    always_comb begin
        taps = '0;
        for (int c = 0; c < WIN_SIZE; c++) begin
            taps[c*DATA_WIDTH +: DATA_WIDTH] = col_r[c];
        end
    end

endmodule

// File: rtl/gaussian_window_5x5.sv
// ---------------------------------------------------------------------------
// gaussian_window_5x5
// Consumer of the 5-row aligned line buffer. Discards the first PIPE_LAT
// samples of a frame (pipeline fill), then treats every enabled sample as
// an aligned column, builds a 5x5 window and emits interior windows only,
// with their centre coordinates. After the last input pixel it raises
// drain so the upstream pipeline keeps stepping until the final column
// has been sampled.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   enable            shared pipeline strobe; all state holds while low
//   sof               start of frame (qualified by enable), input pixel 0
//   row_0..row_4      aligned taps, row_0 oldest line
//   drain             high while flushing the upstream pipeline
//   window            25 taps, tap (r,c) at [(r*5+c)*DATA_WIDTH +: DATA_WIDTH]
//   window_valid      one-cycle strobe per interior window
//   center_x/y        centre coordinate of the emitted window
//   frame_done        one-cycle pulse after the last aligned sample
//   frame_abort       one-cycle pulse when sof arrives mid-frame
// ---------------------------------------------------------------------------
module gaussian_window_5x5
    import gaussian_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int LINE_WIDTH   = 1920,
    parameter int FRAME_HEIGHT = 1080,
    parameter int PIPE_LAT     = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             sof,
    input  logic [DATA_WIDTH-1:0]            row_0,
    input  logic [DATA_WIDTH-1:0]            row_1,
    input  logic [DATA_WIDTH-1:0]            row_2,
    input  logic [DATA_WIDTH-1:0]            row_3,
    input  logic [DATA_WIDTH-1:0]            row_4,
    output logic                             drain,
    output logic [WIN_TAPS*DATA_WIDTH-1:0]   window,
    output logic                             window_valid,
    output logic [$clog2(LINE_WIDTH)-1:0]    center_x,
    output logic [$clog2(FRAME_HEIGHT)-1:0]  center_y,
    output logic                             frame_done,
    output logic                             frame_abort
);

    localparam int CX_W     = $clog2(LINE_WIDTH);
    localparam int CY_W     = $clog2(FRAME_HEIGHT);
    localparam int IN_W     = $clog2(LINE_WIDTH * FRAME_HEIGHT + 1);
    localparam int FILL_W   = $clog2(PIPE_LAT + 1);
    localparam int ROW_BITS = WIN_SIZE * DATA_WIDTH;

    localparam logic [IN_W-1:0]   FRAME_PIXELS = IN_W'(LINE_WIDTH * FRAME_HEIGHT);
    localparam logic [FILL_W-1:0] FILL_DONE    = FILL_W'(PIPE_LAT);
    localparam logic [CX_W-1:0]   COL_LAST     = CX_W'(LINE_WIDTH - 1);
    localparam logic [CY_W-1:0]   LINE_LAST    = CY_W'(FRAME_HEIGHT - 1);
    localparam logic [CX_W-1:0]   COL_MIN      = CX_W'(WIN_SIZE - 1);
    localparam logic [CY_W-1:0]   LINE_MIN     = CY_W'(WIN_SIZE - 1);

    state_t                state_r;
    logic [IN_W-1:0]       in_cnt_r;
    logic [FILL_W-1:0]     fill_cnt_r;
    logic [CX_W-1:0]       col_r;
    logic [CY_W-1:0]       line_r;

    logic [DATA_WIDTH-1:0] rows_s     [WIN_SIZE];
    logic [ROW_BITS-1:0]   col_taps_s [WIN_SIZE];
    logic                  aligned_s;
    logic                  interior_s;
    logic                  last_col_s;
    logic [IN_W-1:0]       in_cnt_next_s;
    logic [WIN_TAPS*DATA_WIDTH-1:0] window_next_s;

    assign rows_s[0] = row_0;
    assign rows_s[1] = row_1;
    assign rows_s[2] = row_2;
    assign rows_s[3] = row_3;
    assign rows_s[4] = row_4;

    for (genvar r = 0; r < WIN_SIZE; r++) begin : g_row
        win_col_shift #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_col_shift (
            .clk      (clk),
            .rst      (rst),
            .shift_en (aligned_s),
            .din      (rows_s[r]),
            .taps     (col_taps_s[r])
        );
    end

    // Sample classification: a sof sample is pixel 0 of a new frame and is
    // never aligned, even when the previous frame had finished filling.
    always_comb begin
        aligned_s = 1'b0;
        if (enable && !sof && (state_r != IDLE) && (fill_cnt_r == FILL_DONE)) begin
            aligned_s = 1'b1;
        end else begin
            aligned_s = 1'b0;
        end
        interior_s    = (col_r >= COL_MIN) && (line_r >= LINE_MIN);
        last_col_s    = (col_r == COL_LAST) && (line_r == LINE_LAST);
        in_cnt_next_s = in_cnt_r + IN_W'(1);
    end

    // Window as it will look after this sample shifts in: the stored columns
    // are one sample behind, so append the live row taps on the right.
    always_comb begin
        window_next_s = '0;
        for (int r = 0; r < WIN_SIZE; r++) begin
            window_next_s[tap_index(r, 0)*DATA_WIDTH +: ROW_BITS] =
                {rows_s[r], col_taps_s[r][ROW_BITS-1:DATA_WIDTH]};
        end
    end

    // Frame FSM, position counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            in_cnt_r     <= '0;
            fill_cnt_r   <= '0;
            col_r        <= '0;
            line_r       <= '0;
            drain        <= 1'b0;
            window       <= '0;
            window_valid <= 1'b0;
            center_x     <= '0;
            center_y     <= '0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
        end else begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
            if (enable) begin
                case (state_r)
                    IDLE: begin
                        if (sof) begin
                            state_r    <= RUN;
                            in_cnt_r   <= IN_W'(1);
                            fill_cnt_r <= FILL_W'(1);
                            col_r      <= '0;
                            line_r     <= '0;
                        end
                    end
                    RUN, FLUSH: begin
                        if (sof) begin
                            // Restart on this pixel; column contents are left
                            // alone since the first columns are never interior.
                            frame_abort <= 1'b1;
                            state_r     <= RUN;
                            drain       <= 1'b0;
                            in_cnt_r    <= IN_W'(1);
                            fill_cnt_r  <= FILL_W'(1);
                            col_r       <= '0;
                            line_r      <= '0;
                        end else begin
                            if (state_r == RUN) begin
                                in_cnt_r <= in_cnt_next_s;
                                if (in_cnt_next_s == FRAME_PIXELS) begin
                                    state_r <= FLUSH;
                                    drain   <= 1'b1;
                                end
                            end
                            if (!aligned_s) begin
                                fill_cnt_r <= fill_cnt_r + FILL_W'(1);
                            end else begin
                                if (interior_s) begin
                                    window_valid <= 1'b1;
                                    window       <= window_next_s;
                                    center_x     <= col_r - CX_W'(2);
                                    center_y     <= line_r - CY_W'(2);
                                end
                                if (col_r == COL_LAST) begin
                                    col_r  <= '0;
                                    line_r <= (line_r == LINE_LAST) ? '0 : line_r + CY_W'(1);
                                end else begin
                                    col_r <= col_r + CX_W'(1);
                                end
                                if ((state_r == FLUSH) && last_col_s) begin
                                    state_r    <= IDLE;
                                    drain      <= 1'b0;
                                    frame_done <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        drain   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gaussian_window_5x5.sv
// ---------------------------------------------------------------------------
// tb_gaussian_window_5x5
// Small-frame bench (8x6) with a behavioural line-buffer model feeding the
// aligned row taps. Expected windows come from the frame image directly.
// ---------------------------------------------------------------------------
module tb_gaussian_window_5x5;

    localparam int DW   = 8;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int PL   = 5;
    localparam int NPIX = W * H;
    localparam int CXW  = $clog2(W);
    localparam int CYW  = $clog2(H);
    localparam int SMAX = 2048;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           sof;
    logic [DW-1:0]  row_0, row_1, row_2, row_3, row_4;
    logic           drain;
    logic [25*DW-1:0] window;
    logic           window_valid;
    logic [CXW-1:0] center_x;
    logic [CYW-1:0] center_y;
    logic           frame_done;
    logic           frame_abort;

    always #5 clk = ~clk;

    gaussian_window_5x5 #(
        .DATA_WIDTH   (DW),
        .LINE_WIDTH   (W),
        .FRAME_HEIGHT (H),
        .PIPE_LAT     (PL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sof          (sof),
        .row_0        (row_0),
        .row_1        (row_1),
        .row_2        (row_2),
        .row_3        (row_3),
        .row_4        (row_4),
        .drain        (drain),
        .window       (window),
        .window_valid (window_valid),
        .center_x     (center_x),
        .center_y     (center_y),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Line-buffer model: every enabled input pixel is appended to a stream;
    // the aligned column for the pixel pushed PL samples ago is presented,
    // with row k reaching back (4-k) lines.
    logic [DW-1:0] stream [SMAX];
    int g = 0;

    typedef struct {
        logic [25*DW-1:0] win;
        int cx;
        int cy;
    } win_rec_t;
    win_rec_t win_q[$];
    int done_cnt  = 0;
    int abort_cnt = 0;

    typedef struct {
        int cx;
        int cy;
        logic [7:0] tap0;
        logic [7:0] tap12;
        logic [7:0] tap24;
    } vec_t;
    vec_t vecs [8];

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (window_valid) win_q.push_back('{window, int'(center_x), int'(center_y)});
        if (frame_done)   done_cnt++;
        if (frame_abort)  abort_cnt++;
    end

    task automatic chk(input string name, input logic [25*DW-1:0] act, input logic [25*DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] pix(input int base, input int x, input int y);
        int v;
        v = base + y * W + x;
        return DW'(v);
    endfunction

    function automatic logic [DW-1:0] tap_row(input int k);
        int idx;
        idx = g - PL - (4 - k) * W;
        if (idx >= 0) return stream[idx % SMAX];
        else return '0;
    endfunction

    function automatic logic [25*DW-1:0] model_win(input int base, input int cx, input int cy);
        logic [25*DW-1:0] w;
        w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[(r*5+c)*DW +: DW] = pix(base, cx - 2 + c, cy - 2 + r);
        return w;
    endfunction

    task automatic step(input bit en, input bit s, input logic [DW-1:0] px);
        @(negedge clk);
        enable = en;
        sof    = s;
        if (en) begin
            row_0 = tap_row(0);
            row_1 = tap_row(1);
            row_2 = tap_row(2);
            row_3 = tap_row(3);
            row_4 = tap_row(4);
            stream[g % SMAX] = px;
            g++;
        end else begin
            row_0 = DW'($urandom);
            row_1 = DW'($urandom);
            row_2 = DW'($urandom);
            row_3 = DW'($urandom);
            row_4 = DW'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int base, input int start, input int n, input bit gap);
        int idx;
        idx = start;
        while (idx < n) begin
            if (gap && ($urandom_range(0, 1) == 0)) begin
                step(1'b0, 1'b0, DW'($urandom));
            end else begin
                step(1'b1, idx == 0, pix(base, idx % W, idx / W));
                idx++;
            end
        end
    endtask

    task automatic drain_until_done(input string name, input bit gap);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            step(gap ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, DW'($urandom));
            if (frame_done) got = 1'b1;
        end
        chk({name, " frame_done timeout"}, got, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, DW'($urandom));
    endtask

    task automatic check_windows(input string name, input int base);
        win_rec_t rec;
        for (int i = 0; i < 8; i++) begin
            if (win_q.size() == 0) begin
                chk($sformatf("%s w%0d missing", name, i), 0, 1);
                break;
            end
            rec = win_q.pop_front();
            chk($sformatf("%s w%0d cx", name, i), rec.cx, vecs[i].cx);
            chk($sformatf("%s w%0d cy", name, i), rec.cy, vecs[i].cy);
            chk($sformatf("%s w%0d tap0", name, i), rec.win[0 +: DW], DW'(vecs[i].tap0 + base));
            chk($sformatf("%s w%0d tap12", name, i), rec.win[12*DW +: DW], DW'(vecs[i].tap12 + base));
            chk($sformatf("%s w%0d tap24", name, i), rec.win[24*DW +: DW], DW'(vecs[i].tap24 + base));
            chk($sformatf("%s w%0d window", name, i), rec.win, model_win(base, vecs[i].cx, vecs[i].cy));
        end
    endtask

    task automatic clear_obs();
        win_q.delete();
        done_cnt  = 0;
        abort_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1;
        // Interior windows of a frame of pixel y*8+x, in emission order.
        vecs[0] = '{2, 2, 8'd0,  8'd18, 8'd36};
        vecs[1] = '{3, 2, 8'd1,  8'd19, 8'd37};
        vecs[2] = '{4, 2, 8'd2,  8'd20, 8'd38};
        vecs[3] = '{5, 2, 8'd3,  8'd21, 8'd39};
        vecs[4] = '{2, 3, 8'd8,  8'd26, 8'd44};
        vecs[5] = '{3, 3, 8'd9,  8'd27, 8'd45};
        vecs[6] = '{4, 3, 8'd10, 8'd28, 8'd46};
        vecs[7] = '{5, 3, 8'd11, 8'd29, 8'd47};

        rst = 1'b1; enable = 1'b0; sof = 1'b0;
        row_0 = '0; row_1 = '0; row_2 = '0; row_3 = '0; row_4 = '0;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("reset window", window, 0);
        chk("reset valid", window_valid, 0);
        chk("reset drain", drain, 0);
        chk("reset done", frame_done, 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        clear_obs();

        // Basic continuous frame with exact drain timing.
        feed(0, 0, NPIX, 1'b0);
        chk("basic drain rise", drain, 1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, DW'($urandom));
            chk($sformatf("basic drain hold %0d", i), drain, 1);
            chk($sformatf("basic early done %0d", i), frame_done, 0);
        end
        step(1'b1, 1'b0, DW'($urandom));
        chk("basic frame_done", frame_done, 1);
        chk("basic drain fall", drain, 0);
        idle(6);
        chk("basic done pulse width", frame_done, 0);
        chk("basic window held", window, model_win(0, 5, 3));
        chk("basic count", win_q.size(), 8);
        chk("basic done count", done_cnt, 1);
        chk("basic abort count", abort_cnt, 0);
        check_windows("basic", 0);

        // Random enable gaps.
        clear_obs();
        b0 = $urandom_range(0, 255);
        feed(b0, 0, NPIX, 1'b1);
        drain_until_done("gap", 1'b1);
        idle(3);
        chk("gap count", win_q.size(), 8);
        chk("gap done count", done_cnt, 1);
        check_windows("gap", b0);

        // sof at input pixel 20 restarts the frame.
        clear_obs();
        b0 = $urandom_range(0, 255);
        b1 = $urandom_range(0, 255);
        feed(b0, 0, 20, 1'b0);
        step(1'b1, 1'b1, pix(b1, 0, 0));
        chk("abort pulse", frame_abort, 1);
        step(1'b1, 1'b0, pix(b1, 1, 0));
        chk("abort pulse width", frame_abort, 0);
        feed(b1, 2, NPIX, 1'b0);
        drain_until_done("abort", 1'b0);
        idle(3);
        chk("abort count", win_q.size(), 8);
        chk("abort pulses", abort_cnt, 1);
        chk("abort done count", done_cnt, 1);
        check_windows("abort", b1);

        // Reset mid-RUN, rows ignored until the next sof.
        clear_obs();
        b0 = $urandom_range(0, 255);
        feed(b0, 0, 20, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0, DW'($urandom));
        chk("rst window", window, 0);
        chk("rst valid", window_valid, 0);
        chk("rst cx", center_x, 0);
        chk("rst cy", center_y, 0);
        chk("rst drain", drain, 0);
        chk("rst done", frame_done, 0);
        chk("rst abort", frame_abort, 0);
        rst = 1'b0;
        idle(12);
        chk("rst idle windows", win_q.size(), 0);
        chk("rst idle drain", drain, 0);
        b1 = $urandom_range(0, 255);
        feed(b1, 0, NPIX, 1'b0);
        drain_until_done("rst", 1'b0);
        idle(3);
        chk("rst count", win_q.size(), 8);
        chk("rst abort count", abort_cnt, 0);
        check_windows("rst", b1);

        // Back-to-back frames.
        clear_obs();
        b0 = $urandom_range(0, 255);
        b1 = $urandom_range(0, 255);
        feed(b0, 0, NPIX, 1'b0);
        drain_until_done("b2b_a", 1'b0);
        feed(b1, 0, NPIX, 1'b0);
        drain_until_done("b2b_b", 1'b0);
        idle(3);
        chk("b2b count", win_q.size(), 16);
        chk("b2b done count", done_cnt, 2);
        chk("b2b abort count", abort_cnt, 0);
        check_windows("b2b_a", b0);
        check_windows("b2b_b", b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
